ps2_rx_datapath: RTL and testbench
==================================

PS2_RX_DATAPATH -- requirements
Module: ps2_rx_datapath

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal synchronized ps2_c samples needed to change the filtered clock level (legal range 2..16).
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-004 ps2_c  in  1  raw PS/2 clock line, asynchronous to clk.
REQ-005 ps2_d  in  1  raw PS/2 data line, asynchronous to clk.
REQ-006 ShiftEna  in  1  shift-enable from the receive FSM; one bit is captured per high cycle.
REQ-007 resetCbits  in  1  bit-counter clear from the receive FSM.
REQ-008 rx_done  in  1  frame-complete strobe from the receive FSM.
REQ-009 ps2_c_sync  out  1  filtered PS/2 clock; feeds the FSM ps2_c input.
REQ-010 ps2_d_sync  out  1  synchronized PS/2 data; feeds the FSM ps2_d input.
REQ-011 fall_edge  out  1  one-cycle pulse on a filtered-clock falling edge.
REQ-012 trama_terminada  out  1  high while the bit count equals 11.
REQ-013 dout  out  8  last received data byte.
REQ-014 dout_valid  out  1  one-cycle pulse when dout updates.
REQ-015 parity_err  out  1  odd-parity failure flag for the last frame.
REQ-016 frame_err  out  1  start/stop-bit failure flag for the last frame.

Function
REQ-017 ps2_c and ps2_d SHALL each pass through a 2-flop synchronizer; ps2_d_sync is the second flop of the data synchronizer.
REQ-018 Filter: ps2_c_sync SHALL go to 1 after FILTER_LEN consecutive synchronized samples of 1, go to 0 after FILTER_LEN consecutive samples of 0, and otherwise hold its value.
REQ-019 fall_edge SHALL be high for exactly one cycle, in the cycle after ps2_c_sync changes from 1 to 0; it is never high on a rising edge.
REQ-020 Shift register (11 bits): when ShiftEna=1 and count<11, it SHALL shift right with ps2_d_sync inserted at bit 10 (LSB-first frame). After 11 shifts: bit0=start, bits8:1=data, bit9=parity, bit10=stop.
REQ-021 Bit counter (4 bits): increments on ShiftEna; saturates at 11, and ShiftEna at 11 leaves the counter and shift register unchanged.
REQ-022 resetCbits=1 SHALL clear the counter to 0 in the next cycle and has priority over a simultaneous ShiftEna; the shift register is not cleared.
REQ-023 trama_terminada = (count==11), combinational from the counter register.
REQ-024 On rx_done=1: dout<=shreg[8:1], dout_valid<=1 for the next cycle only, and parity_err/frame_err updated; the flags hold until the next rx_done.
REQ-025 dout holds its value between rx_done strobes; rx_done while count<11 still latches dout and the flags (no suppression).

Reset
REQ-026 While rst=0: synchronizer flops and ps2_c_sync =1, filter counter =0, shift register =0, count =0, fall_edge=0, dout=8'h00, dout_valid=0, parity_err=0, frame_err=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no fall_edge is generated on reset release.

Configuration
REQ-028 With macro PS2_RX_PARITY_CHECK_EN defined: parity_err = ~^shreg[9:1] (odd parity over data plus parity bit fails), and frame_err = shreg[0] | ~shreg[10].
REQ-029 Without PS2_RX_PARITY_CHECK_EN: parity_err and frame_err are tied to 0 and no check logic is synthesized; dout behaviour is unchanged.

Verification
REQ-030 Frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), bit period 2000 clk, with an FSM model -> 11 fall_edge pulses, trama_terminada=1 after the 11th shift, dout=8'h1C, one dout_valid pulse, parity_err=0, frame_err=0.
REQ-031 Same frame with parity bit 1 -> dout=8'h1C, parity_err=1 when the macro is defined and 0 when it is not.
REQ-032 Stop bit 0 -> frame_err=1 (macro defined).
REQ-033 3-cycle low glitch on ps2_c with FILTER_LEN=8 -> no fall_edge and ps2_c_sync remains 1.
REQ-034 rst=0 after 5 shifts, then a full frame for 0xF0 -> count restarts at 0, dout=8'hF0, parity_err=0.
REQ-035 resetCbits and ShiftEna in the same cycle at count=4 -> count=0 in the next cycle.

Source files
------------

// File: rtl/ps2_rx_datapath_if.sv
// ps2_rx_datapath_if: groups the signals exchanged between the PS/2 receive
// datapath and its controlling FSM / byte consumer.
//   master : receive FSM side (drives shift/clear/done strobes)
//   slave  : datapath side (drives synchronized lines, edge, byte and flags)
interface ps2_rx_datapath_if;
  logic       ShiftEna;
  logic       resetCbits;
  logic       rx_done;
  logic       ps2_c_sync;
  logic       ps2_d_sync;
  logic       fall_edge;
  logic       trama_terminada;
  logic [7:0] dout;
  logic       dout_valid;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ShiftEna, resetCbits, rx_done,
    input  ps2_c_sync, ps2_d_sync, fall_edge, trama_terminada,
    input  dout, dout_valid, parity_err, frame_err
  );

  modport slave (
    input  ShiftEna, resetCbits, rx_done,
    output ps2_c_sync, ps2_d_sync, fall_edge, trama_terminada,
    output dout, dout_valid, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx_datapath.sv
// ps2_rx_datapath: PS/2 receive datapath. Synchronizes and glitch-filters the
// raw PS/2 clock, synchronizes the data line, detects filtered falling edges,
// shifts in an 11-bit LSB-first frame under FSM control and presents the data
// byte with an optional parity/framing check.
// Optional feature: define PS2_RX_PARITY_CHECK_EN to enable the odd-parity and
// start/stop-bit checks; otherwise parity_err and frame_err are tied low.
module ps2_rx_datapath #(
  parameter int FILTER_LEN = 8  // legal range 2..16
) (
  input  logic              clk,
  input  logic              rst,    // asynchronous, active low
  input  logic              ps2_c,
  input  logic              ps2_d,
  ps2_rx_datapath_if.slave  bus
);

  localparam int                FCNT_W     = $clog2(FILTER_LEN);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FILTER_LEN - 1);
  localparam logic [3:0]        FRAME_BITS = 4'd11;

  logic              c_meta, c_sync;
  logic              d_meta, d_sync;
  logic [FCNT_W-1:0] filt_cnt;
  logic              filt_level;
  logic              filt_flip;
  logic              fall_edge_q;
  logic [10:0]       shreg;
  logic [3:0]        bit_cnt;
  logic [7:0]        dout_q;
  logic              dout_valid_q;

  // Two-flop synchronizers for both raw PS/2 lines; idle level of the bus is 1.
  // NOTE: sequential state is always updated with <= so every flop samples the
  // pre-edge value of its neighbour; blocking = here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2_c;
      c_sync <= c_meta;
      d_meta <= ps2_d;
      d_sync <= d_meta;
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  assign filt_flip = (c_sync != filt_level) && (filt_cnt == FCNT_LAST);

  // Clock glitch filter: count samples that disagree with the current level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt   <= '0;
      filt_level <= 1'b1;
    end else if (c_sync == filt_level) begin
      filt_cnt   <= '0;
    end else if (filt_flip) begin
      filt_cnt   <= '0;
      filt_level <= c_sync;
    end else begin
      filt_cnt   <= filt_cnt + 1'b1;
    end
  end

  // Falling-edge pulse, registered so it coincides with the first low cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fall_edge_q <= 1'b0;
    else      fall_edge_q <= filt_flip & filt_level;
  end

  // Frame shift register and bit counter; clear wins over a simultaneous shift.
  // NOTE: the shift register is reset even though it is pure datapath, so the
  // byte presented after a premature rx_done is deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bus.resetCbits) begin
      bit_cnt <= '0;
    end else if (bus.ShiftEna && (bit_cnt < FRAME_BITS)) begin
      shreg   <= {d_sync, shreg[10:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Output byte and one-cycle valid strobe, captured on every rx_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= bus.rx_done;
      if (bus.rx_done) dout_q <= shreg[8:1];
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_err_q;
  logic frame_err_q;

  // Frame checks: odd parity over data+parity, start must be 0, stop must be 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (bus.rx_done) begin
      parity_err_q <= ~^shreg[9:1];
      frame_err_q  <= shreg[0] | ~shreg[10];
    end
  end

  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
`else
  // Start, parity and stop bits have no consumer when checking is disabled.
  logic unused_frame_bits;
  assign unused_frame_bits = ^{shreg[10:9], shreg[0]};

  assign bus.parity_err = 1'b0;
  assign bus.frame_err  = 1'b0;
`endif

  assign bus.ps2_c_sync      = filt_level;
  assign bus.ps2_d_sync      = d_sync;
  assign bus.fall_edge       = fall_edge_q;
  assign bus.trama_terminada = (bit_cnt == FRAME_BITS);
  assign bus.dout            = dout_q;
  assign bus.dout_valid      = dout_valid_q;

endmodule

// File: tb/tb_ps2_rx_datapath.sv
// tb_ps2_rx_datapath: directed self-checking bench for ps2_rx_datapath.
// A small receive-FSM model reacts to fall_edge with ShiftEna pulses, then
// strobes rx_done and resetCbits once the frame is complete.
module tb_ps2_rx_datapath;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  logic ps2_c;
  logic ps2_d;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int dv_cnt   = 0;

  ps2_rx_datapath_if bus ();

  ps2_rx_datapath #(.FILTER_LEN(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .ps2_c (ps2_c),
    .ps2_d (ps2_d),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.fall_edge === 1'b1)  fe_cnt++;
    if (bus.dout_valid === 1'b1) dv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  // Drive nbits of a frame LSB-first; data is set half a bit before the falling clock.
  task automatic drive_frame(input logic [10:0] fr, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      ps2_d = fr[i];
      repeat (half) @(negedge clk);
      ps2_c = 1'b0;
      repeat (half) @(negedge clk);
      ps2_c = 1'b1;
    end
    repeat (half) @(negedge clk);
  endtask

  // Receive-FSM model: one ShiftEna per fall_edge, then rx_done and counter clear.
  task automatic fsm_model(input int nshift, input int budget, input bit do_done);
    logic found;
    for (int i = 0; i < nshift; i++) begin
      found = 1'b0;
      for (int c = 0; c < budget && !found; c++) begin
        @(negedge clk);
        found = (bus.fall_edge === 1'b1);
      end
      if (!found) begin
        check("fall_edge_wait", 32'(found), 32'd1);
        return;
      end
      bus.ShiftEna = 1'b1;
      @(negedge clk);
      bus.ShiftEna = 1'b0;
      if (i == 9) check("trama_low_after_10", 32'(bus.trama_terminada), 32'd0);
    end
    if (do_done) begin
      check("trama_high_after_11", 32'(bus.trama_terminada), 32'd1);
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
      check("dout_valid_pulse", 32'(bus.dout_valid), 32'd1);
      bus.resetCbits = 1'b1;
      @(negedge clk);
      bus.resetCbits = 1'b0;
      check("dout_valid_one_cycle", 32'(bus.dout_valid), 32'd0);
      check("trama_cleared", 32'(bus.trama_terminada), 32'd0);
    end
  endtask

  // Direct shift without PS/2 clock activity: settle data through the synchronizer first.
  task automatic shift_bit(input logic b);
    ps2_d = b;
    repeat (3) @(negedge clk);
    bus.ShiftEna = 1'b1;
    @(negedge clk);
    bus.ShiftEna = 1'b0;
  endtask

  initial begin
    int          fe0;
    int          dv0;
    logic        low_seen;
    logic [10:0] fr;

    rst            = 1'b0;
    ps2_c          = 1'b1;
    ps2_d          = 1'b1;
    bus.ShiftEna   = 1'b0;
    bus.resetCbits = 1'b0;
    bus.rx_done    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ps2_c_sync", 32'(bus.ps2_c_sync), 32'd1);
    check("rst_ps2_d_sync", 32'(bus.ps2_d_sync), 32'd1);
    check("rst_fall_edge",  32'(bus.fall_edge), 32'd0);
    check("rst_trama",      32'(bus.trama_terminada), 32'd0);
    check("rst_dout",       32'(bus.dout), 32'h00);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    check("rst_frame_err",  32'(bus.frame_err), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Frame 0x1C, bit period 2000 clk
    fe0 = fe_cnt;
    dv0 = dv_cnt;
    fork
      drive_frame(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1000);
      fsm_model(11, 4100, 1'b1);
    join
    check("f1c_fall_edges", 32'(fe_cnt - fe0), 32'd11);
    check("f1c_dout_valid", 32'(dv_cnt - dv0), 32'd1);
    check("f1c_dout",       32'(bus.dout), 32'h1C);
    check("f1c_parity_err", 32'(bus.parity_err), 32'd0);
    check("f1c_frame_err",  32'(bus.frame_err), 32'd0);

    // Same frame with wrong parity bit
    fork
      drive_frame(mk_frame(8'h1C, 1'b1, 1'b1), 11, 100);
      fsm_model(11, 450, 1'b1);
    join
    check("par_dout",       32'(bus.dout), 32'h1C);
    check("par_parity_err", 32'(bus.parity_err), 32'(CHK));
    check("par_frame_err",  32'(bus.frame_err), 32'd0);
    repeat (50) @(negedge clk);
    check("par_flag_holds", 32'(bus.parity_err), 32'(CHK));

    // Stop bit 0
    fork
      drive_frame(mk_frame(8'h1C, 1'b0, 1'b0), 11, 100);
      fsm_model(11, 450, 1'b1);
    join
    check("stop_dout",       32'(bus.dout), 32'h1C);
    check("stop_frame_err",  32'(bus.frame_err), 32'(CHK));
    check("stop_parity_err", 32'(bus.parity_err), 32'd0);

    // 3-cycle low glitch on ps2_c
    fe0      = fe_cnt;
    low_seen = 1'b0;
    ps2_c    = 1'b0;
    repeat (3) @(negedge clk);
    ps2_c = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ps2_c_sync !== 1'b1) low_seen = 1'b1;
    end
    check("glitch_c_sync_low", 32'(low_seen), 32'd0);
    check("glitch_fall_edge",  32'(fe_cnt - fe0), 32'd0);

    // Clear wins over simultaneous shift at count 4, then saturation at 11
    fr = mk_frame(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) shift_bit(1'b0);
    bus.resetCbits = 1'b1;
    bus.ShiftEna   = 1'b1;
    @(negedge clk);
    bus.resetCbits = 1'b0;
    bus.ShiftEna   = 1'b0;
    check("clr_prio_trama", 32'(bus.trama_terminada), 32'd0);
    for (int i = 0; i < 10; i++) shift_bit(fr[i]);
    check("clr_prio_after_10", 32'(bus.trama_terminada), 32'd0);
    shift_bit(fr[10]);
    check("clr_prio_after_11", 32'(bus.trama_terminada), 32'd1);
    shift_bit(1'b0);
    check("sat_trama_holds", 32'(bus.trama_terminada), 32'd1);
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    check("sat_dout",       32'(bus.dout), 32'hA5);
    check("sat_parity_err", 32'(bus.parity_err), 32'd0);
    check("sat_frame_err",  32'(bus.frame_err), 32'd0);

    // rx_done with a partial frame still latches: 4 ones shifted onto the 0xA5 frame
    bus.resetCbits = 1'b1;
    @(negedge clk);
    bus.resetCbits = 1'b0;
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    dv0 = dv_cnt;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    check("partial_dout_valid", 32'(bus.dout_valid), 32'd1);
    check("partial_dout",       32'(bus.dout), 32'hFA);
    @(negedge clk);
    check("partial_dv_count",   32'(dv_cnt - dv0), 32'd1);
    bus.resetCbits = 1'b1;
    @(negedge clk);
    bus.resetCbits = 1'b0;

    // Reset after 5 shifts, then a full 0xF0 frame
    fork
      drive_frame(mk_frame(8'hF0, 1'b1, 1'b1), 5, 100);
      fsm_model(5, 450, 1'b0);
    join
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_dout",       32'(bus.dout), 32'h00);
    check("midrst_trama",      32'(bus.trama_terminada), 32'd0);
    check("midrst_c_sync",     32'(bus.ps2_c_sync), 32'd1);
    check("midrst_fall_edge",  32'(bus.fall_edge), 32'd0);
    check("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
    fe0 = fe_cnt;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("release_no_fall_edge", 32'(fe_cnt - fe0), 32'd0);
    fork
      drive_frame(mk_frame(8'hF0, 1'b1, 1'b1), 11, 100);
      fsm_model(11, 450, 1'b1);
    join
    check("ff0_dout",       32'(bus.dout), 32'hF0);
    check("ff0_parity_err", 32'(bus.parity_err), 32'd0);
    check("ff0_frame_err",  32'(bus.frame_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
